purchase_driver: RTL and testbench
==================================

PURCHASE_DRIVER -- requirements
Module: purchase_driver

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 SHALL have port coin_valid, input, 1, offers coin_in for loading into the coin queue.
REQ-004 SHALL have port coin_in, input, 2, coin code: 00=10c, 01=25c, 10=50c, 11=100c.
REQ-005 SHALL have port coin_ready, output, 1, queue accepts coin this cycle.
REQ-006 SHALL have port start, input, 1, begin purchase of sel_product.
REQ-007 SHALL have port sel_product, input, 2, product code, sampled on accepted start.
REQ-008 SHALL have port product, output, 2, product code driven to vendor.
REQ-009 SHALL have port coin, output, 2, coin code driven to vendor.
REQ-010 SHALL have port drop_coin, output, 1, coin strobe to vendor.
REQ-011 SHALL have port finish_coin, output, 1, end-of-payment strobe to vendor.
REQ-012 SHALL have port drop_product, output, 1, collect strobe to vendor.
REQ-013 SHALL have port motor, input, 1, vendor dispense indication (success).
REQ-014 SHALL have port LED, input, 3, vendor status; 3'b111 = error.
REQ-015 SHALL have port busy, output, 1, purchase in progress.
REQ-016 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-017 SHALL have port status, output, 2, result: 00 OK, 01 ERR, 10 TIMEOUT, 11 EMPTY; held until next start.
REQ-018 SHALL have port total_cents, output, 9, sum of coins dropped in current/last purchase.

Function
REQ-019 SHALL hold a 4-entry coin FIFO; coin_ready = !full && state==IDLE; coin loaded on coin_valid && coin_ready.
REQ-020 SHALL register all outputs to the vendor; no combinational path from inputs to vendor outputs.
REQ-021 SHALL implement FSM states IDLE, SELECT, DROP, GAP, FINISH, WAIT, COLLECT, DONE.
REQ-022 SHALL accept start only in IDLE; start in any other state ignored.
REQ-023 SHALL, if start and coin_valid coincide in IDLE, load the coin before the start-time empty check.
REQ-024 SHALL, on accepted start with FIFO empty (after REQ-023), go to DONE with status 11, no vendor strobe.
REQ-025 SHALL, on accepted start with coins, latch sel_product, clear total_cents, enter SELECT; product driven from SELECT until return to IDLE.
REQ-026 SHALL in DROP drive coin=FIFO head, drop_coin=1 for exactly one cycle, add coin value to total_cents.
REQ-027 SHALL in GAP drive drop_coin=0, pop FIFO; next state DROP if not empty, else FINISH.
REQ-028 SHALL in FINISH assert finish_coin for exactly one cycle, then enter WAIT and clear a 4-bit timeout counter.
REQ-029 SHALL in WAIT: motor=1 -> COLLECT; else LED==3'b111 -> DONE status 01; motor takes priority if both.
REQ-030 SHALL, after 16 WAIT cycles without response, enter DONE with status 10.
REQ-031 SHALL in COLLECT assert drop_product for one cycle, then DONE with status 00.
REQ-032 SHALL in DONE pulse done for one cycle, drop busy, return to IDLE; product returns to 00.
REQ-033 SHALL keep busy=1 in all states except IDLE.
REQ-034 SHALL compute total_cents without overflow (max 400 fits 9 bits).

Reset
REQ-035 SHALL on reset=0 clear: FSM to IDLE, FIFO empty, product/coin=00, all strobes 0, busy=0, done=0, status=00, total_cents=0.
REQ-036 SHALL, on reset asserted mid-purchase, abort immediately with no done pulse.

Verification
REQ-037 SHALL cover: reset=0 one cycle -> all outputs 0, coin_ready=1.
REQ-038 SHALL cover: load 01,01; start product 00; motor=1 two cycles after finish_coin -> two drop_coin pulses two cycles apart with coin=01, one finish_coin, one drop_product, done with status 00, total_cents=50.
REQ-039 SHALL cover: load 11; start product 11; vendor LED=111 in WAIT -> status 01, no drop_product, total_cents=100.
REQ-040 SHALL cover: load 00; start; no vendor response -> done 16 cycles after WAIT entry, status 10.
REQ-041 SHALL cover: start with FIFO empty -> done next cycle, status 11, vendor outputs never toggle.
REQ-042 SHALL cover: offer 5 coins in IDLE -> fifth refused (coin_ready=0); then start, reset=0 during DROP -> all outputs 0, FIFO empty, no done.

Source files
------------

// File: rtl/purchase_driver_if.sv
// purchase_driver_if: coin queue, purchase control and vendor
// signals of the purchase driver, bundled by direction.
interface purchase_driver_if;
    logic       coin_valid;
    logic [1:0] coin_in;
    logic       coin_ready;
    logic       start;
    logic [1:0] sel_product;
    logic [1:0] product;
    logic [1:0] coin;
    logic       drop_coin;
    logic       finish_coin;
    logic       drop_product;
    logic       motor;
    logic [2:0] LED;
    logic       busy;
    logic       done;
    logic [1:0] status;
    logic [8:0] total_cents;

    modport slave (
        input  coin_valid, coin_in, start, sel_product, motor, LED,
        output coin_ready, product, coin, drop_coin, finish_coin,
        output drop_product, busy, done, status, total_cents
    );

    modport master (
        output coin_valid, coin_in, start, sel_product, motor, LED,
        input  coin_ready, product, coin, drop_coin, finish_coin,
        input  drop_product, busy, done, status, total_cents
    );
endinterface

// File: rtl/purchase_driver.sv
// purchase_driver: queues coins, then pays them one by one into a
// vending machine and collects the product, reporting the outcome.
module purchase_driver (
    input  logic             clk,
    input  logic             reset,
    purchase_driver_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, SELECT, DROP, GAP, FINISH, WAIT, COLLECT, DONE
    } state_t;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_ERR   = 2'b01;
    localparam logic [1:0] ST_TMO   = 2'b10;
    localparam logic [1:0] ST_EMPTY = 2'b11;

    state_t     state_q;
    logic [1:0] fifo_q [4];
    logic [1:0] wr_q, rd_q;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] tmo_q;

    logic [1:0] product_q, coin_q, status_q;
    logic       drop_coin_q, finish_coin_q, drop_product_q;
    logic       busy_q, done_q;
    logic [8:0] total_q;

    logic       ready, push, pop;
    logic [1:0] head, head_nxt;

    function automatic logic [8:0] coin_val(input logic [1:0] c);
        unique case (c)
            2'b00: coin_val = 9'd10;
            2'b01: coin_val = 9'd25;
            2'b10: coin_val = 9'd50;
            2'b11: coin_val = 9'd100;
        endcase
    endfunction

    assign ready    = (cnt_q != 3'd4) && (state_q == IDLE);
    assign push     = bus.coin_valid && ready;
    assign pop      = (state_q == GAP);
    assign head     = fifo_q[rd_q];
    assign head_nxt = fifo_q[rd_q + 2'd1];

    // Occupancy: loads only happen in IDLE and pops only in GAP.
    always_comb begin
        cnt_d = cnt_q;
        if (push)
            cnt_d = cnt_q + 3'd1;
        else if (pop)
            cnt_d = cnt_q - 3'd1;
    end

    // Coin storage; the pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_q] <= bus.coin_in;
    end

    // Queue pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q  <= 2'd0;
            rd_q  <= 2'd0;
            cnt_q <= 3'd0;
        end else begin
            if (push)
                wr_q <= wr_q + 2'd1;
            if (pop)
                rd_q <= rd_q + 2'd1;
            cnt_q <= cnt_d;
        end
    end

    // Purchase sequencer with registered vendor and status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            tmo_q          <= 4'd0;
            product_q      <= 2'd0;
            coin_q         <= 2'd0;
            drop_coin_q    <= 1'b0;
            finish_coin_q  <= 1'b0;
            drop_product_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            status_q       <= ST_OK;
            total_q        <= 9'd0;
        end else begin
            drop_coin_q    <= 1'b0;
            finish_coin_q  <= 1'b0;
            drop_product_q <= 1'b0;
            done_q         <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (cnt_q == 3'd0 && !push) begin
                            state_q  <= DONE;
                            status_q <= ST_EMPTY;
                            done_q   <= 1'b1;
                        end else begin
                            state_q   <= SELECT;
                            product_q <= bus.sel_product;
                            status_q  <= ST_OK;
                            total_q   <= 9'd0;
                        end
                    end
                end
                SELECT: begin
                    state_q     <= DROP;
                    coin_q      <= head;
                    drop_coin_q <= 1'b1;
                    total_q     <= total_q + coin_val(head);
                end
                DROP: state_q <= GAP;
                GAP: begin
                    if (cnt_q > 3'd1) begin
                        state_q     <= DROP;
                        coin_q      <= head_nxt;
                        drop_coin_q <= 1'b1;
                        total_q     <= total_q + coin_val(head_nxt);
                    end else begin
                        state_q       <= FINISH;
                        finish_coin_q <= 1'b1;
                    end
                end
                FINISH: begin
                    state_q <= WAIT;
                    tmo_q   <= 4'd0;
                end
                WAIT: begin
                    if (bus.motor) begin
                        state_q        <= COLLECT;
                        drop_product_q <= 1'b1;
                    end else if (bus.LED == 3'b111) begin
                        state_q  <= DONE;
                        status_q <= ST_ERR;
                        done_q   <= 1'b1;
                    end else if (tmo_q == 4'd15) begin
                        state_q  <= DONE;
                        status_q <= ST_TMO;
                        done_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 4'd1;
                    end
                end
                COLLECT: begin
                    state_q  <= DONE;
                    status_q <= ST_OK;
                    done_q   <= 1'b1;
                end
                DONE: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    product_q <= 2'd0;
                    coin_q    <= 2'd0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.coin_ready   = ready;
    assign bus.product      = product_q;
    assign bus.coin         = coin_q;
    assign bus.drop_coin    = drop_coin_q;
    assign bus.finish_coin  = finish_coin_q;
    assign bus.drop_product = drop_product_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.status       = status_q;
    assign bus.total_cents  = total_q;
endmodule

// File: tb/tb_purchase_driver.sv
// tb_purchase_driver: directed and random purchases checked against
// a cycle-timeline model of the purchase sequence.
module tb_purchase_driver;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_total = 0;
    int   cval [4];

    purchase_driver_if bus ();

    purchase_driver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_outs"}, 64'({bus.product, bus.coin, bus.drop_coin,
            bus.finish_coin, bus.drop_product, bus.busy, bus.done,
            bus.status, bus.total_cents}), 64'd0);
        chk({tag, "_ready"}, 64'(bus.coin_ready), 64'd1);
    endtask

    // mode: 0 motor, 1 LED error, 2 no response, 3 motor+LED together
    task automatic purchase(input int n, input logic [7:0] cs,
                            input logic [1:0] prod, input int mode,
                            input int w, input bit coinc);
        logic [63:0] e_drop, e_fin, e_prd, e_done, e_busy, e_rdy;
        logic [63:0] o_drop, o_fin, o_prd, o_done, o_busy, o_rdy;
        logic [63:0] o_pbad, o_cnz;
        logic [7:0]  o_coins, e_coins;
        logic [1:0]  e_st, st_done, e_prod;
        int dk, sum, nd, kv;
        e_drop = '0; e_fin = '0; e_prd = '0; e_done = '0;
        e_busy = '0; e_rdy = '0; o_drop = '0; o_fin = '0;
        o_prd = '0; o_done = '0; o_busy = '0; o_rdy = '0;
        o_pbad = '0; o_cnz = '0; o_coins = '0; e_coins = '0;
        st_done = 2'd0; nd = 0; sum = 0;
        kv = 2 * n + 2 + w;
        if (n == 0) begin
            dk = 0; e_st = 2'b11; sum = last_total;
        end else begin
            for (int i = 0; i < n; i++) begin
                sum += cval[cs[2*i+:2]];
                e_drop[2*i+1] = 1'b1;
                e_coins[2*i+:2] = cs[2*i+:2];
            end
            e_fin[2*n+1] = 1'b1;
            if (mode == 0 || mode == 3) begin
                dk = 2 * n + 4 + w; e_st = 2'b00;
                e_prd[2*n+3+w] = 1'b1;
            end else if (mode == 1) begin
                dk = 2 * n + 3 + w; e_st = 2'b01;
            end else begin
                dk = 2 * n + 18; e_st = 2'b10;
            end
        end
        e_done[dk] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k <= dk) e_busy[k] = 1'b1;
            else e_rdy[k] = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.coin_valid = 1'b1;
            bus.coin_in = cs[2*i+:2];
            if (i == n - 1 && coinc) begin
                bus.start = 1'b1;
                bus.sel_product = prod;
            end
            chk("load_ready", 64'(bus.coin_ready), 64'd1);
            @(posedge clk);
        end
        if (!(n > 0 && coinc)) begin
            @(negedge clk);
            bus.coin_valid = 1'b0;
            bus.start = 1'b1;
            bus.sel_product = prod;
            @(posedge clk);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            e_prod = (n > 0 && k <= dk) ? prod : 2'd0;
            o_drop[k] = bus.drop_coin;
            o_fin[k]  = bus.finish_coin;
            o_prd[k]  = bus.drop_product;
            o_done[k] = bus.done;
            o_busy[k] = bus.busy;
            o_rdy[k]  = bus.coin_ready;
            o_pbad[k] = (bus.product !== e_prod);
            o_cnz[k]  = (bus.coin !== 2'd0);
            if (bus.drop_coin === 1'b1) begin
                if (nd < 4) o_coins[2*nd+:2] = bus.coin;
                nd++;
            end
            if (k == dk) st_done = bus.status;
            bus.motor = (mode == 0 || mode == 3) && n > 0 && k == kv;
            if ((mode == 1 || mode == 3) && n > 0 && k == kv)
                bus.LED = 3'b111;
            else
                bus.LED = 3'($urandom_range(0, 6));
            if (k <= dk) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.coin_valid = 1'($urandom_range(0, 1));
                bus.coin_in = 2'($urandom_range(0, 3));
                bus.sel_product = 2'($urandom_range(0, 3));
            end else begin
                bus.start = 1'b0;
                bus.coin_valid = 1'b0;
            end
        end
        chk("drop_coin_cycles", o_drop, e_drop);
        chk("coin_codes", 64'(o_coins), 64'(e_coins));
        chk("drop_count", 64'(nd), 64'(n));
        chk("finish_cycles", o_fin, e_fin);
        chk("drop_product_cycles", o_prd, e_prd);
        chk("done_cycles", o_done, e_done);
        chk("busy_cycles", o_busy, e_busy);
        chk("ready_cycles", o_rdy, e_rdy);
        chk("product_bad_cycles", o_pbad, 64'd0);
        chk("status_at_done", 64'(st_done), 64'(e_st));
        chk("status_held", 64'(bus.status), 64'(e_st));
        chk("total_cents", 64'(bus.total_cents), 64'(sum));
        if (n == 0) chk("coin_idle", o_cnz, 64'd0);
        last_total = sum;
    endtask

    initial begin
        int n, mode, w;
        bit done_seen;
        cval[0] = 10; cval[1] = 25; cval[2] = 50; cval[3] = 100;
        reset = 1'b0;
        bus.coin_valid = 1'b0; bus.coin_in = 2'd0;
        bus.start = 1'b0; bus.sel_product = 2'd0;
        bus.motor = 1'b0; bus.LED = 3'd0;
        @(posedge clk);
        @(negedge clk);
        chk_cleared("reset");
        reset = 1'b1;

        purchase(2, 8'b0000_0101, 2'b00, 0, 1, 1'b0);
        purchase(1, 8'b0000_0011, 2'b11, 1, 3, 1'b0);
        purchase(1, 8'b0000_0000, 2'b01, 2, 0, 1'b0);
        purchase(0, 8'd0, 2'b10, 0, 0, 1'b0);
        purchase(4, 8'b1110_0100, 2'b10, 3, 15, 1'b1);
        purchase(3, 8'b0011_1001, 2'b01, 1, 15, 1'b1);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.coin_valid = 1'b1;
            bus.coin_in = 2'($urandom_range(0, 3));
            chk(i < 4 ? "fill_ready" : "fifth_refused",
                64'(bus.coin_ready), i < 4 ? 64'd1 : 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        bus.coin_valid = 1'b0;
        bus.start = 1'b1;
        bus.sel_product = 2'b10;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("in_drop", 64'(bus.drop_coin), 64'd1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk_cleared("mid_reset");
        done_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen = 1'b1;
        end
        chk("no_done_after_abort", 64'(done_seen), 64'd0);
        last_total = 0;
        purchase(0, 8'd0, 2'b01, 0, 0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            n = $urandom_range(0, 4);
            mode = $urandom_range(0, 3);
            w = $urandom_range(0, 15);
            purchase(n, 8'($urandom), 2'($urandom_range(0, 3)), mode, w,
                     1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
